// File: rtl/dcache_drain.sv
// Drains the dcache request queue one entry at a time into a req/ack memory port,
// aligning byte lanes on writes, extracting lanes on reads and returning a one-cycle completion.
module dcache_drain #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int TIMEOUTBITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATABITS-1:0] queue_out_data,
  input  logic [ADDRBITS-1:0] queue_out_addr,
  input  logic                queue_out_rdreq,
  input  logic                queue_out_wrreq,
  input  logic [1:0]          queue_out_wordlen,
  input  logic                queue_not_empty,
  output logic                queue_pop,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_wdata,
  output logic [3:0]          mem_byteenable,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  input  logic                mem_ack,
  input  logic [DATABITS-1:0] mem_rdata,
  output logic                resp_valid,
  output logic [DATABITS-1:0] resp_data,
  output logic                resp_err,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // Last count value before the wait is abandoned (2**TIMEOUTBITS-1 cycles of request).
  localparam logic [TIMEOUTBITS-1:0] TO_LAST = TIMEOUTBITS'((2 ** TIMEOUTBITS) - 2);

  state_t                 r_state;
  logic                   r_live;
  logic [1:0]             r_off;
  logic [1:0]             r_wl;
  logic                   r_rd;
  logic [TIMEOUTBITS-1:0] r_cnt;
  logic [ADDRBITS-1:0]    r_mem_addr;
  logic [DATABITS-1:0]    r_mem_wdata;
  logic [3:0]             r_mem_be;
  logic                   r_mem_rdreq;
  logic                   r_mem_wrreq;
  logic                   r_resp_valid;
  logic [DATABITS-1:0]    r_resp_data;
  logic                   r_resp_err;

  logic                   w_pop;
  logic                   w_err;
  logic [3:0]             w_be;
  logic [DATABITS-1:0]    w_wdata;
  logic [DATABITS-1:0]    w_rsh;
  logic [DATABITS-1:0]    w_rext;

  // r_live keeps pop low while reset is held, even with a non-empty queue.
  assign w_pop = r_live && (r_state == IDLE) && queue_not_empty;

  always_comb begin
    w_err = (queue_out_rdreq && queue_out_wrreq) || (queue_out_wordlen == 2'd3) ||
            (queue_out_wordlen == 2'd1 && queue_out_addr[0]) ||
            (queue_out_wordlen == 2'd2 && queue_out_addr[1:0] != 2'd0);
    case (queue_out_wordlen)
      2'd0:    begin
        w_be    = 4'b0001 << queue_out_addr[1:0];
        w_wdata = {4{queue_out_data[7:0]}};
      end
      2'd1:    begin
        w_be    = 4'b0011 << queue_out_addr[1:0];
        w_wdata = {2{queue_out_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = queue_out_data;
      end
    endcase
  end

  always_comb begin
    w_rsh = mem_rdata >> {r_off, 3'b000};
    case (r_wl)
      2'd0:    w_rext = {24'd0, w_rsh[7:0]};
      2'd1:    w_rext = {16'd0, w_rsh[15:0]};
      default: w_rext = w_rsh;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_live       <= 1'b0;
      r_off        <= '0;
      r_wl         <= '0;
      r_rd         <= 1'b0;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_mem_rdreq  <= 1'b0;
      r_mem_wrreq  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: if (w_pop) begin
          r_off <= queue_out_addr[1:0];
          r_wl  <= queue_out_wordlen;
          r_rd  <= queue_out_rdreq;
          if (w_err) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
            r_state      <= RESP;
          end else if (queue_out_rdreq || queue_out_wrreq) begin
            r_mem_addr  <= {queue_out_addr[ADDRBITS-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be;
            r_mem_rdreq <= queue_out_rdreq;
            r_mem_wrreq <= queue_out_wrreq;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            r_mem_rdreq  <= 1'b0;
            r_mem_wrreq  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= r_rd ? w_rext : '0;
            r_state      <= RESP;
          end else if (r_cnt == TO_LAST) begin
            r_mem_rdreq  <= 1'b0;
            r_mem_wrreq  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
            r_cnt        <= r_cnt + 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= '0;
          r_cnt        <= '0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign queue_pop      = w_pop;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_byteenable = r_mem_be;
  assign mem_rdreq      = r_mem_rdreq;
  assign mem_wrreq      = r_mem_wrreq;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_dcache_drain.sv
// Randomized bench for dcache_drain: a queue source, a latency-programmable memory
// responder and an arithmetic reference of the expected memory beat and completion.
module tb_dcache_drain;
  localparam int TOB   = 4;
  localparam int TO_CY = (1 << TOB) - 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic        wr;
    logic [1:0]  wl;
  } ent_t;

  logic        clk, reset_n;
  logic [31:0] queue_out_data, queue_out_addr;
  logic        queue_out_rdreq, queue_out_wrreq, queue_not_empty, queue_pop;
  logic [1:0]  queue_out_wordlen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_data;
  logic [3:0]  mem_byteenable;
  logic        mem_rdreq, mem_wrreq, mem_ack, resp_valid, resp_err, busy;

  ent_t q[$];
  int   n_chk, n_err, pops;

  dcache_drain #(.DATABITS(32), .ADDRBITS(32), .TIMEOUTBITS(TOB)) dut (
    .clk(clk), .reset_n(reset_n),
    .queue_out_data(queue_out_data), .queue_out_addr(queue_out_addr),
    .queue_out_rdreq(queue_out_rdreq), .queue_out_wrreq(queue_out_wrreq),
    .queue_out_wordlen(queue_out_wordlen), .queue_not_empty(queue_not_empty),
    .queue_pop(queue_pop), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteenable(mem_byteenable), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue source consumes its head on each pop edge.
  always @(posedge clk) begin
    if (reset_n && queue_pop === 1'b1) begin
      chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
      pops++;
      if (q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic drive_head();
    if (q.size() != 0) begin
      queue_not_empty   = 1'b1;
      queue_out_addr    = q[0].addr;
      queue_out_data    = q[0].data;
      queue_out_rdreq   = q[0].rd;
      queue_out_wrreq   = q[0].wr;
      queue_out_wordlen = q[0].wl;
    end else begin
      queue_not_empty   = 1'b0;
      queue_out_addr    = '0;
      queue_out_data    = '0;
      queue_out_rdreq   = 1'b0;
      queue_out_wrreq   = 1'b0;
      queue_out_wordlen = '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_head();
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_ctl"}, 32'({queue_pop, mem_rdreq, mem_wrreq, resp_valid, resp_err, busy,
                            mem_byteenable}), 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, resp_data, 32'd0);
  endtask

  // Serves one entry (optionally pushing it first) and checks beat and completion.
  // lat = request cycles that pass before ack is raised; >= TO_CY means no ack in time.
  task automatic service(input ent_t e, input int lat, input logic [31:0] rdat, input bit push);
    bit          err, drop, seen, done;
    int          held, sz, p0;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    logic [63:0] mask;
    err  = (e.rd && e.wr) || e.wl == 2'd3 || (e.wl == 2'd1 && e.addr[0]) ||
           (e.wl == 2'd2 && e.addr[1:0] != 2'd0);
    drop = !err && !e.rd && !e.wr;
    sz   = (e.wl == 2'd0) ? 1 : (e.wl == 2'd1) ? 2 : 4;
    ebe  = 4'(((1 << sz) - 1) << e.addr[1:0]);
    ewd  = (sz == 1) ? 32'(e.data[7:0]) * 32'h01010101 :
           (sz == 2) ? 32'(e.data[15:0]) * 32'h00010001 : e.data;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    erd  = 32'((64'(rdat) >> (8 * e.addr[1:0])) & mask);
    p0 = pops; held = 0; seen = 0; done = 0;
    if (push) q.push_back(e);
    for (int c = 0; c < 80 && !done; c++) begin
      step();
      if (mem_rdreq || mem_wrreq) begin
        if (!seen) chk("busy_issue", 32'(busy), 32'd1);
        seen = 1;
        held++;
        chk("mem_addr", mem_addr, {e.addr[31:2], 2'b00});
        chk("mem_be", 32'(mem_byteenable), 32'(ebe));
        chk("mem_req", 32'({mem_rdreq, mem_wrreq}), 32'({e.rd, e.wr}));
        if (e.wr) chk("mem_wdata", mem_wdata, ewd);
        mem_ack   = (held > lat);
        mem_rdata = (held > lat) ? rdat : $urandom;
      end else begin
        // Stray acks outside an access must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (resp_valid) begin
        done = 1;
        if (drop) chk("drop_resp", 32'd1, 32'd0);
        else if (err) begin
          chk("err_flag", 32'(resp_err), 32'd1);
          chk("err_data", resp_data, 32'd0);
          chk("err_noreq", 32'(seen), 32'd0);
        end else begin
          chk("resp_err", 32'(resp_err), 32'(lat >= TO_CY));
          chk("resp_data", resp_data, (e.rd && lat < TO_CY) ? erd : 32'd0);
          chk("req_cycles", 32'(held), 32'((lat >= TO_CY) ? TO_CY : lat + 1));
        end
        chk("one_pop", 32'(pops - p0), 32'd1);
      end else if (drop && pops != p0 && c >= 4) begin
        done = 1;
        chk("drop_noreq", 32'(seen), 32'd0);
        chk("drop_pop", 32'(pops - p0), 32'd1);
      end
    end
    chk("done_in_bound", 32'(done), 32'd1);
    step();
    mem_ack = 1'b0;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  ent_t e;
  int   lat, r, bad;

  initial begin
    n_chk = 0; n_err = 0; pops = 0;
    reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive_head();
    repeat (3) step();
    rst_checks("reset");
    reset_n = 1'b1;
    step();

    e = '{addr: 32'h1000, data: 32'h0, rd: 1, wr: 0, wl: 2'd2};
    service(e, 3, 32'hDEADBEEF, 1);
    e = '{addr: 32'h2003, data: 32'h000000A5, rd: 0, wr: 1, wl: 2'd0};
    service(e, 0, 32'h0, 1);
    e = '{addr: 32'h3002, data: 32'h0, rd: 1, wr: 0, wl: 2'd1};
    service(e, 1, 32'h12345678, 1);
    e = '{addr: 32'h4001, data: 32'h0, rd: 1, wr: 0, wl: 2'd2};
    service(e, 0, 32'h0, 1);
    e = '{addr: 32'h5004, data: 32'h0, rd: 1, wr: 0, wl: 2'd2};
    service(e, 100, 32'h0, 1);
    e = '{addr: 32'h6000, data: 32'h11223344, rd: 0, wr: 1, wl: 2'd1};
    service(e, 2, 32'h0, 1);
    e = '{addr: 32'h7001, data: 32'h0, rd: 1, wr: 0, wl: 2'd0};
    service(e, TO_CY - 1, 32'hCAFEF00D, 1);
    e = '{addr: 32'h8000, data: 32'h0, rd: 0, wr: 0, wl: 2'd2};
    service(e, 0, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      e.addr = $urandom;
      e.data = $urandom;
      e.wl   = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      e.rd = (r == 0) || (r >= 2 && r < 6);
      e.wr = (r == 0) || (r >= 6);
      r = $urandom_range(0, 9);
      lat = (r == 0) ? TO_CY + 2 : (r == 1) ? TO_CY - 1 : $urandom_range(0, 4);
      service(e, lat, $urandom, 1);
    end

    // Three queued entries; reset lands while the second is waiting for ack.
    e = '{addr: 32'h9000, data: 32'h0, rd: 1, wr: 0, wl: 2'd2};
    q.push_back(e);
    e.addr = 32'h9004; q.push_back(e);
    e.addr = 32'h9008; q.push_back(e);
    e.addr = 32'h9000;
    service(e, 1, 32'h0BADF00D, 0);
    mem_ack = 1'b0;
    bad = 1;
    for (int c = 0; c < 10 && bad != 0; c++) begin
      step();
      mem_ack = 1'b0;
      if (mem_rdreq) bad = 0;
    end
    chk("second_issue", 32'(bad), 32'd0);
    step();
    reset_n = 1'b0;
    #1;
    rst_checks("midreset");
    q.delete();
    step();
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (resp_valid || mem_rdreq || mem_wrreq) bad++;
    end
    chk("no_resp_after_reset", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
